// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// fifo_pkg : shared types and helpers for the synchronous FIFO family
// Revision : 1.0
// ============================================================================
package fifo_pkg;

    // clog2 wrapper that never returns zero, so a 1-entry array still has an address bit
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    typedef struct packed {
        logic wfull;
        logic rempty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage
`default_nettype wire

// File: rtl/param_sync_fifo_if.sv
`default_nettype none
// ============================================================================
// param_sync_fifo_if : producer/consumer bundle for param_sync_fifo
// Revision : 1.0
// ============================================================================
interface param_sync_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = fifo_pkg::addr_width(DEPTH) + 1;

    logic             clr;
    logic             winc;
    logic [WIDTH-1:0] wdata;
    logic             rinc;
    logic [WIDTH-1:0] rdata;
    logic             wfull;
    logic             rempty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output clr, winc, wdata, rinc,
        input  rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  clr, winc, wdata, rinc,
        output rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
// sync_fifo_mem : DEPTH x WIDTH register array, one write port, async read
// Revision : 1.0
// ============================================================================
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [addr_width(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]             wdata,
    input  logic [addr_width(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]             rdata_comb
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata_comb = r_mem[raddr];
endmodule
`default_nettype wire

// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
// param_sync_fifo : single-clock FIFO with count, thresholds, FWFT, flush
// Revision : 1.0
// ============================================================================
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic               clk,
    input  logic               rst,
    param_sync_fifo_if.slave   bus
);
    localparam int AW = addr_width(DEPTH);

    localparam logic [AW:0] c_one      = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] c_af_level = AF_LEVEL[AW:0];
    localparam logic [AW:0] c_ae_level = AE_LEVEL[AW:0];

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("param_sync_fifo: DEPTH must be a power of two >= 2");
        end
        if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
            $error("param_sync_fifo: AF_LEVEL out of range 1..DEPTH");
        end
        if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
            $error("param_sync_fifo: AE_LEVEL out of range 0..DEPTH-1");
        end
    endgenerate

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             r_underflow;
    fifo_status_t     w_status;
    logic             w_wen;
    logic             w_ren;
    logic [WIDTH-1:0] w_mem_rdata;

    // Flags decode only from registered pointers/count, never from winc/rinc
    assign w_status.wfull        = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_status.rempty       = (r_wptr == r_rptr);
    assign w_status.almost_full  = (r_count >= c_af_level);
    assign w_status.almost_empty = (r_count <= c_ae_level);
    assign w_status.overflow     = r_overflow;
    assign w_status.underflow    = r_underflow;

    assign w_wen = bus.winc & ~w_status.wfull  & ~bus.clr;
    assign w_ren = bus.rinc & ~w_status.rempty & ~bus.clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wen) r_wptr <= r_wptr + c_one;
            if (w_ren) r_rptr <= r_rptr + c_one;
            case ({w_wen, w_ren})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
            if (bus.winc && w_status.wfull)  r_overflow  <= 1'b1;
            if (bus.rinc && w_status.rempty) r_underflow <= 1'b1;
        end
    end

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk        (clk),
        .we         (w_wen & ~rst),
        .waddr      (r_wptr[AW-1:0]),
        .wdata      (bus.wdata),
        .raddr      (r_rptr[AW-1:0]),
        .rdata_comb (w_mem_rdata)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.rdata = w_mem_rdata;
        end else begin : g_std
            logic [WIDTH-1:0] r_rdata;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata <= '0;
                end else if (w_ren) begin
                    r_rdata <= w_mem_rdata;
                end
            end
            assign bus.rdata = r_rdata;
        end
    endgenerate

    assign bus.wfull        = w_status.wfull;
    assign bus.rempty       = w_status.rempty;
    assign bus.almost_full  = w_status.almost_full;
    assign bus.almost_empty = w_status.almost_empty;
    assign bus.overflow     = w_status.overflow;
    assign bus.underflow    = w_status.underflow;
    assign bus.count        = r_count;
endmodule
`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
`default_nettype none
// ============================================================================
// tb_param_sync_fifo : standard and FWFT instances driven in lockstep vs a queue model
// Revision : 1.0
// ============================================================================
module tb_param_sync_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    param_sync_fifo_if #(.WIDTH(8), .DEPTH(16)) if0 ();
    param_sync_fifo_if #(.WIDTH(8), .DEPTH(16)) if1 ();

    param_sync_fifo #(.DEPTH(16), .WIDTH(8), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0))
        u_std  (.clk(clk), .rst(rst), .bus(if0));
    param_sync_fifo #(.DEPTH(16), .WIDTH(8), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1))
        u_fwft (.clk(clk), .rst(rst), .bus(if1));

    int checks = 0;
    int fails  = 0;

    logic [7:0] q[$];
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;
    logic [7:0] m_rd0 = 8'h00;

    function automatic logic [10:0] exp_st();
        return {q.size() == 16, q.size() == 0, q.size() >= 14, q.size() <= 2,
                m_ovf, m_udf, 5'(q.size())};
    endfunction

    function automatic logic [10:0] act_st0();
        return {if0.wfull, if0.rempty, if0.almost_full, if0.almost_empty,
                if0.overflow, if0.underflow, if0.count};
    endfunction

    function automatic logic [10:0] act_st1();
        return {if1.wfull, if1.rempty, if1.almost_full, if1.almost_empty,
                if1.overflow, if1.underflow, if1.count};
    endfunction

    task automatic cycle(input bit r, input bit c, input bit wi, input logic [7:0] wd, input bit ri);
        bit full, empty;
        rst = r;
        if0.clr = c;  if0.winc = wi; if0.wdata = wd; if0.rinc = ri;
        if1.clr = c;  if1.winc = wi; if1.wdata = wd; if1.rinc = ri;
        @(posedge clk);
        full  = (q.size() == 16);
        empty = (q.size() == 0);
        if (r) begin
            q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_rd0 = 8'h00;
        end else if (c) begin
            q.delete();
        end else begin
            if (wi && full)  m_ovf = 1'b1;
            if (ri && empty) m_udf = 1'b1;
            if (ri && !empty) m_rd0 = q.pop_front();
            if (wi && !full)  q.push_back(wd);
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 8'h00, 0);
        cycle(1, 0, 0, 8'h00, 0);
        checks++;
        if (act_st0() !== 11'b01_01_00_00000) begin
            fails++; $display("FAIL reset_status got %b want %b", act_st0(), 11'b01010000000);
        end
        checks++;
        if (if0.rdata !== 8'h00) begin
            fails++; $display("FAIL reset_rdata got %h want 00", if0.rdata);
        end
        cycle(0, 0, 0, 8'h00, 0);
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 1, 8'(i), 0);
            checks++;
            if (act_st0() !== exp_st()) begin
                fails++; $display("FAIL fill_status[%0d] got %b want %b", i, act_st0(), exp_st());
            end
        end
        cycle(0, 0, 1, 8'hAA, 0);
        checks++;
        if (if0.overflow !== 1'b1 || if0.count !== 5'd16 || if0.wfull !== 1'b1) begin
            fails++; $display("FAIL overflow_17th got ovf=%b cnt=%0d want ovf=1 cnt=16", if0.overflow, if0.count);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (if1.rdata !== 8'(i)) begin
                fails++; $display("FAIL fwft_head[%0d] got %h want %h", i, if1.rdata, 8'(i));
            end
            cycle(0, 0, 0, 8'h00, 1);
            checks++;
            if (if0.rdata !== 8'(i) || act_st0() !== exp_st()) begin
                fails++; $display("FAIL drain[%0d] got %h/%b want %h/%b", i, if0.rdata, act_st0(), 8'(i), exp_st());
            end
        end
        checks++;
        if (if0.rempty !== 1'b1) begin
            fails++; $display("FAIL drain_empty got %b want 1", if0.rempty);
        end
    endtask

    task automatic test_underflow();
        cycle(0, 0, 0, 8'h00, 1);
        checks++;
        if (if0.underflow !== 1'b1 || if0.count !== 5'd0 || if0.rdata !== 8'h0F) begin
            fails++; $display("FAIL underflow got udf=%b cnt=%0d rd=%h want 1/0/0f", if0.underflow, if0.count, if0.rdata);
        end
        for (int i = 0; i < 6; i++) cycle(0, 0, i < 3, 8'(8'hB0 + i), i >= 3);
        checks++;
        if (if0.underflow !== 1'b1 || act_st0() !== exp_st()) begin
            fails++; $display("FAIL underflow_sticky got %b want %b", act_st0(), exp_st());
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, 8'(8'h40 + i), 0);
        for (int k = 0; k < 40; k++) begin
            cycle(0, 0, 1, 8'(8'h48 + k), 1);
            checks++;
            if (if0.count !== 5'd8 || if0.rdata !== 8'(8'h40 + k) || act_st0() !== exp_st()) begin
                fails++; $display("FAIL simul[%0d] got cnt=%0d rd=%h want cnt=8 rd=%h", k, if0.count, if0.rdata, 8'(8'h40 + k));
            end
        end
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, 8'(8'h70 + i), 0);
        cycle(0, 0, 1, 8'hEE, 1);
        checks++;
        if (if0.count !== 5'd15 || act_st0() !== exp_st()) begin
            fails++; $display("FAIL full_wr_rd got cnt=%0d want 15", if0.count);
        end
        for (int i = 0; i < 15; i++) begin
            cycle(0, 0, 0, 8'h00, 1);
            checks++;
            if (if0.rdata !== m_rd0 || if0.rdata === 8'hEE) begin
                fails++; $display("FAIL full_drain[%0d] got %h want %h", i, if0.rdata, m_rd0);
            end
        end
    endtask

    task automatic test_fwft();
        cycle(0, 0, 1, 8'h5A, 0);
        checks++;
        if (if1.rempty !== 1'b0 || if1.rdata !== 8'h5A) begin
            fails++; $display("FAIL fwft_visible got empty=%b rd=%h want 0/5a", if1.rempty, if1.rdata);
        end
        cycle(0, 0, 0, 8'h00, 1);
        checks++;
        if (if1.rempty !== 1'b1 || if0.rdata !== 8'h5A) begin
            fails++; $display("FAIL fwft_pop got empty=%b std_rd=%h want 1/5a", if1.rempty, if0.rdata);
        end
    endtask

    task automatic test_clr();
        logic [7:0] held;
        for (int i = 0; i < 9; i++) cycle(0, 0, 1, 8'(8'hC0 + i), 0);
        held = if0.rdata;
        cycle(0, 1, 1, 8'hFF, 1);
        checks++;
        if (if0.count !== 5'd0 || if0.rempty !== 1'b1 || if0.overflow !== 1'b1 || if0.rdata !== held) begin
            fails++; $display("FAIL clr got cnt=%0d empty=%b ovf=%b rd=%h want 0/1/1/%h", if0.count, if0.rempty, if0.overflow, if0.rdata, held);
        end
        cycle(0, 0, 1, 8'h33, 0);
        checks++;
        if (if1.rdata !== 8'h33 || if0.count !== 5'd1) begin
            fails++; $display("FAIL clr_wr got rd=%h cnt=%0d want 33/1", if1.rdata, if0.count);
        end
        cycle(0, 0, 0, 8'h00, 1);
        checks++;
        if (if0.rdata !== 8'h33) begin
            fails++; $display("FAIL clr_rd got %h want 33", if0.rdata);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 8'(8'hD0 + i), 0);
        cycle(1, 0, 1, 8'hD5, 0);
        checks++;
        if (act_st0() !== 11'b01_01_00_00000 || if0.rdata !== 8'h00 || act_st1() !== 11'b01_01_00_00000) begin
            fails++; $display("FAIL mid_reset got %b rd=%h want 01010000000 rd=00", act_st0(), if0.rdata);
        end
        cycle(0, 0, 1, 8'h77, 0);
        cycle(0, 0, 0, 8'h00, 1);
        checks++;
        if (if0.rdata !== 8'h77 || if0.rempty !== 1'b1) begin
            fails++; $display("FAIL post_reset got %h want 77", if0.rdata);
        end
    endtask

    task automatic test_random();
        bit r, c, wi, ri;
        for (int n = 0; n < 800; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            c  = ($urandom_range(0, 39) == 0);
            wi = ($urandom_range(0, 99) < ((n / 100) % 2 ? 70 : 35));
            ri = ($urandom_range(0, 99) < ((n / 100) % 2 ? 35 : 70));
            cycle(r, c, wi, 8'($urandom), ri);
            checks++;
            if (act_st0() !== exp_st() || act_st1() !== exp_st() || if0.rdata !== m_rd0
                || (q.size() != 0 && if1.rdata !== q[0])) begin
                fails++;
                $display("FAIL random[%0d] got %b/%b rd0=%h rd1=%h want %b rd0=%h", n,
                         act_st0(), act_st1(), if0.rdata, if1.rdata, exp_st(), m_rd0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_underflow();
        test_simultaneous();
        test_fwft();
        test_clr();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
`default_nettype wire
